// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the 5-stage pipeline: register-field and word types, the
// pipeline controller state enum and the bundle of latch enables/flushes.
// ---------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

    // One enable/flush set for every pipeline latch.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic exmem_flush;
        logic memwb_en;
    } latch_ctrl_t;

    localparam latch_ctrl_t CTRL_FREEZE = '0;
    localparam latch_ctrl_t CTRL_FLOW   = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                           idex_en: 1'b1, idex_flush: 1'b0, exmem_en: 1'b1,
                                           exmem_flush: 1'b0, memwb_en: 1'b1};

endpackage : cpu_types_pkg

// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
// Hazard/status inputs and latch-control outputs of the pipeline controller.
//   master : datapath side (drives ihit/dhit/decode/EX/MEM status, reads controls)
//   slave  : controller side (pipeline_ctrl)
// Optional macro PIPE_PERF_EN adds cycle_cnt, stall_cnt and flush_cnt.
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if
    import cpu_types_pkg::*;
    ;
    logic     ihit;
    logic     dhit;
    regbits_t de_rs;
    regbits_t de_rt;
    logic     de_halt;
    logic     ex_dREN;
    regbits_t ex_regDst;
    logic     br_taken;
    logic     mem_dREN;
    logic     mem_dWEN;

    logic     pc_en;
    logic     ifid_en;
    logic     ifid_flush;
    logic     idex_en;
    logic     idex_flush;
    logic     exmem_en;
    logic     exmem_flush;
    logic     memwb_en;
    logic     halted;

`ifdef PIPE_PERF_EN
    word_t    cycle_cnt;
    word_t    stall_cnt;
    word_t    flush_cnt;

    modport master (
        output ihit, dhit, de_rs, de_rt, de_halt, ex_dREN, ex_regDst, br_taken, mem_dREN, mem_dWEN,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en,
        input  halted, cycle_cnt, stall_cnt, flush_cnt
    );
    modport slave (
        input  ihit, dhit, de_rs, de_rt, de_halt, ex_dREN, ex_regDst, br_taken, mem_dREN, mem_dWEN,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en,
        output halted, cycle_cnt, stall_cnt, flush_cnt
    );
`else
    modport master (
        output ihit, dhit, de_rs, de_rt, de_halt, ex_dREN, ex_regDst, br_taken, mem_dREN, mem_dWEN,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en,
        input  halted
    );
    modport slave (
        input  ihit, dhit, de_rs, de_rt, de_halt, ex_dREN, ex_regDst, br_taken, mem_dREN, mem_dWEN,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en,
        output halted
    );
`endif

endinterface : pipeline_ctrl_if

// File: rtl/pipeline_ctrl_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Load-use detector: a load in EX whose destination is a source of the
// instruction in ID. Register $0 is hardwired and never creates a hazard.
//   ex_dren, ex_reg_dst : load flag and destination of the EX instruction
//   de_rs, de_rt        : source fields of the ID instruction
//   load_use            : stall request
// ---------------------------------------------------------------------------
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic     ex_dren,
    input  regbits_t ex_reg_dst,
    input  regbits_t de_rs,
    input  regbits_t de_rt,
    output logic     load_use
);

    assign load_use = ex_dren && (ex_reg_dst != '0) &&
                      ((ex_reg_dst == de_rs) || (ex_reg_dst == de_rt));

endmodule : hazard_detect

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Stall/flush sequencer for the 5-stage pipeline. Produces PC and pipeline
// latch enables/flushes from memory waits, taken branches, load-use hazards
// and fetch misses; a halt in ID drains EX/MEM/WB then freezes the pipe.
//   CLK, nRST : clock, asynchronous active-low reset
//   pif       : pipeline_ctrl_if.slave (status in, enables/flushes/halted out)
// Optional macro PIPE_PERF_EN adds cycle/stall/flush performance counters.
// ---------------------------------------------------------------------------
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 2
) (
    input  logic            CLK,
    input  logic            nRST,
    pipeline_ctrl_if.slave  pif
);

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic             halted_q, halted_d;
    latch_ctrl_t      ctrl;
    logic             mem_wait;
    logic             load_use;

    hazard_detect u_hazard_detect (
        .ex_dren    (pif.ex_dREN),
        .ex_reg_dst (pif.ex_regDst),
        .de_rs      (pif.de_rs),
        .de_rt      (pif.de_rt),
        .load_use   (load_use)
    );

    assign mem_wait = (pif.mem_dREN | pif.mem_dWEN) & ~pif.dhit;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        ctrl        = CTRL_FREEZE;
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;

        unique case (state_q)
            RUN: begin
                if (mem_wait) begin
                    ctrl = CTRL_FREEZE;
                end else if (pif.br_taken) begin
                    // Redirect: squash both younger instructions (IF and ID).
                    ctrl            = CTRL_FLOW;
                    ctrl.ifid_flush = 1'b1;
                    ctrl.idex_flush = 1'b1;
                end else if (load_use) begin
                    // Hold PC and IF/ID, bubble into EX while the load moves on.
                    ctrl            = CTRL_FLOW;
                    ctrl.pc_en      = 1'b0;
                    ctrl.ifid_en    = 1'b0;
                    ctrl.idex_flush = 1'b1;
                end else if (!pif.ihit) begin
                    ctrl            = CTRL_FLOW;
                    ctrl.pc_en      = 1'b0;
                    ctrl.ifid_flush = 1'b1;
                end else begin
                    ctrl = CTRL_FLOW;
                end

                // The halt only counts once it actually advances out of ID.
                if (pif.de_halt && ctrl.idex_en && !ctrl.idex_flush && !mem_wait) begin
                    state_d     = DRAIN;
                    drain_cnt_d = CNT_W'(DRAIN_CYCLES);
                end
            end

            DRAIN: begin
                if (!mem_wait) begin
                    ctrl            = CTRL_FLOW;
                    ctrl.pc_en      = 1'b0;
                    ctrl.ifid_flush = 1'b1;
                    drain_cnt_d     = drain_cnt_q - CNT_W'(1);
                    if (drain_cnt_q == CNT_W'(1)) begin
                        state_d = HALTED;
                    end
                end
            end

            HALTED: begin
                ctrl = CTRL_FREEZE;
            end

            default: begin
                state_d = RUN;
            end
        endcase

        halted_d = (state_d == HALTED);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all flops update together.
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            halted_q    <= halted_d;
        end
    end

    assign pif.pc_en       = ctrl.pc_en;
    assign pif.ifid_en     = ctrl.ifid_en;
    assign pif.ifid_flush  = ctrl.ifid_flush;
    assign pif.idex_en     = ctrl.idex_en;
    assign pif.idex_flush  = ctrl.idex_flush;
    assign pif.exmem_en    = ctrl.exmem_en;
    assign pif.exmem_flush = ctrl.exmem_flush;
    assign pif.memwb_en    = ctrl.memwb_en;
    assign pif.halted      = halted_q;

`ifdef PIPE_PERF_EN
    word_t cycle_cnt_q, cycle_cnt_d;
    word_t stall_cnt_q, stall_cnt_d;
    word_t flush_cnt_q, flush_cnt_d;
    logic  stall_evt, flush_evt;

    // Events are counted as resolved by the priority above, so a branch
    // held across a memory wait is counted once, when it redirects.
    always_comb begin
        stall_evt   = 1'b0;
        flush_evt   = 1'b0;
        if (state_q == RUN) begin
            stall_evt = mem_wait | (~pif.br_taken & (load_use | ~pif.ihit));
            flush_evt = ~mem_wait & pif.br_taken;
        end else if (state_q == DRAIN) begin
            stall_evt = mem_wait;
        end
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q != HALTED) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
            stall_cnt_d = stall_cnt_q + word_t'(stall_evt);
            flush_cnt_d = flush_cnt_q + word_t'(flush_evt);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pif.cycle_cnt = cycle_cnt_q;
    assign pif.stall_cnt = stall_cnt_q;
    assign pif.flush_cnt = flush_cnt_q;
`endif

endmodule : pipeline_ctrl

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed and randomized stimulus for pipeline_ctrl, checked each cycle
// against a behavioural model of the stall/flush/halt rules.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;
    import cpu_types_pkg::*;

    localparam int DRAIN = 3;

    logic CLK;
    logic nRST;
    int   n_pass  = 0;
    int   n_total = 0;

    pipeline_ctrl_if pif ();

    pipeline_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(2)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .pif  (pif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural model: which phase the pipe is in and how many
    // unstalled drain cycles remain before it freezes.
    bit          m_draining;
    bit          m_halted;
    int          m_left;
    int unsigned m_cyc, m_stall, m_flush;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic bit mw();
        return (pif.mem_dREN || pif.mem_dWEN) && !pif.dhit;
    endfunction

    function automatic bit lu();
        return pif.ex_dREN && pif.ex_regDst != 5'd0 &&
               (pif.ex_regDst == pif.de_rs || pif.ex_regDst == pif.de_rt);
    endfunction

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, halted}
    function automatic logic [8:0] dut_vec();
        return {pif.pc_en, pif.ifid_en, pif.ifid_flush, pif.idex_en, pif.idex_flush,
                pif.exmem_en, pif.exmem_flush, pif.memwb_en, pif.halted};
    endfunction

    function automatic logic [8:0] model_vec();
        if (m_halted)          return 9'b0_0_0_0_0_0_0_0_1;
        if (mw())              return 9'b0;
        if (m_draining)        return 9'b0_1_1_1_0_1_0_1_0;
        if (pif.br_taken)      return 9'b1_1_1_1_1_1_0_1_0;
        if (lu())              return 9'b0_0_0_1_1_1_0_1_0;
        if (!pif.ihit)         return 9'b0_1_1_1_0_1_0_1_0;
        return 9'b1_1_0_1_0_1_0_1_0;
    endfunction

    task automatic model_reset();
        m_draining = 0; m_halted = 0; m_left = 0;
        m_cyc = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic idle();
        pif.ihit = 1; pif.dhit = 1; pif.de_rs = 0; pif.de_rt = 0; pif.de_halt = 0;
        pif.ex_dREN = 0; pif.ex_regDst = 0; pif.br_taken = 0;
        pif.mem_dREN = 0; pif.mem_dWEN = 0;
    endtask

    // One clock: compare at the falling edge, then advance the model across the rising edge.
    task automatic tick(string tag);
        bit n_draining, n_halted;
        int n_left;
        int unsigned n_cyc, n_stall, n_flush;
        @(negedge CLK);
        check(tag, 64'(dut_vec()), 64'(model_vec()));
`ifdef PIPE_PERF_EN
        check({tag, "_cyc"},   64'(pif.cycle_cnt), 64'(m_cyc));
        check({tag, "_stall"}, 64'(pif.stall_cnt), 64'(m_stall));
        check({tag, "_flush"}, 64'(pif.flush_cnt), 64'(m_flush));
`endif
        n_draining = m_draining; n_halted = m_halted; n_left = m_left;
        n_cyc = m_cyc; n_stall = m_stall; n_flush = m_flush;
        if (!m_halted) begin
            n_cyc++;
            if (mw() || (!m_draining && !pif.br_taken && (lu() || !pif.ihit))) n_stall++;
            if (!m_draining && !mw() && pif.br_taken) n_flush++;
            if (m_draining) begin
                if (!mw()) begin
                    n_left = m_left - 1;
                    if (n_left == 0) begin n_draining = 0; n_halted = 1; end
                end
            end else if (pif.de_halt && !mw() && !pif.br_taken && !lu()) begin
                n_draining = 1; n_left = DRAIN;
            end
        end
        @(posedge CLK);
        #1;
        m_draining = n_draining; m_halted = n_halted; m_left = n_left;
        m_cyc = n_cyc; m_stall = n_stall; m_flush = n_flush;
    endtask

    // Asynchronous reset mid-cycle; the pipe must be back in RUN before any edge.
    task automatic do_reset(string tag);
        idle();
        nRST = 0;
        #1;
        check({tag, "_halted"}, 64'(pif.halted), 64'(0));
        check({tag, "_run_pc_en"}, 64'(pif.pc_en), 64'(1));
        check({tag, "_run_ifid_flush"}, 64'(pif.ifid_flush), 64'(0));
        #1;
        @(posedge CLK);
        #1;
        nRST = 1;
        model_reset();
    endtask

    initial begin
        int n;
        int frozen;
        idle();
        model_reset();
        nRST = 0;
        #3;
        check("reset_halted", 64'(pif.halted), 64'(0));
        @(posedge CLK);
        #1;
        nRST = 1;
        tick("reset_outputs");

        // Load-use on rs, stalls exactly one cycle.
        pif.ex_dREN = 1; pif.ex_regDst = 5'd8; pif.de_rs = 5'd8;
        tick("load_use_stall");
        pif.ex_dREN = 0;
        tick("load_use_after");
        // Load-use on rt.
        pif.ex_dREN = 1; pif.ex_regDst = 5'd9; pif.de_rs = 5'd1; pif.de_rt = 5'd9;
        tick("load_use_rt");
        // Destination $0 never stalls.
        pif.ex_regDst = 5'd0; pif.de_rs = 5'd0; pif.de_rt = 5'd0;
        tick("load_use_r0");
        idle();

        // Branch with a halt in ID: halt discarded, pipe keeps running.
        pif.br_taken = 1; pif.de_halt = 1;
        tick("branch_halt");
        idle();
        tick("branch_after");
        check("branch_no_drain", 64'(pif.pc_en), 64'(1));

        // Data wait of four cycles, branch asserted for part of it.
        frozen = 0;
        for (int i = 0; i < 4; i++) begin
            pif.mem_dREN = 1; pif.dhit = 0; pif.br_taken = (i >= 2);
            #1;
            if ({pif.pc_en, pif.ifid_en, pif.idex_en, pif.exmem_en, pif.memwb_en} == 5'b0) frozen++;
            tick("dwait_freeze");
        end
        check("dwait_frozen_cycles", 64'(frozen), 64'(4));
        pif.dhit = 1; pif.br_taken = 0;
        tick("dwait_release");
        idle();

        // Halt, reset while draining.
        pif.de_halt = 1;
        tick("halt_accept");
        idle();
        check("drain_pc_en", 64'(pif.pc_en), 64'(0));
        tick("drain_first");
        do_reset("reset_in_drain");
        tick("after_drain_reset");

        // Plain halt: halted exactly DRAIN+1 cycles after the halt cycle.
        pif.de_halt = 1;
        tick("halt2_accept");
        idle();
        n = 1;
        while (!pif.halted && n < 20) begin tick("halt2_drain"); n++; end
        check("halt_latency", 64'(n), 64'(DRAIN + 1));
        tick("halted_frozen");
        tick("halted_frozen2");
        do_reset("reset_in_halted");

        // Halt with two memory-wait cycles during the drain.
        pif.de_halt = 1;
        tick("halt3_accept");
        idle();
        n = 1;
        tick("halt3_drain"); n++;
        pif.mem_dWEN = 1; pif.dhit = 0;
        tick("halt3_wait"); n++;
        tick("halt3_wait"); n++;
        idle();
        while (!pif.halted && n < 20) begin tick("halt3_drain"); n++; end
        check("halt_latency_wait", 64'(n), 64'(DRAIN + 3));
        do_reset("reset_after_halt3");

`ifdef PIPE_PERF_EN
        // Ten cycles: two load-use stalls and one branch.
        for (int i = 0; i < 10; i++) begin
            idle();
            if (i == 1 || i == 4) begin pif.ex_dREN = 1; pif.ex_regDst = 5'd3; pif.de_rt = 5'd3; end
            if (i == 6) pif.br_taken = 1;
            tick("perf_seq");
        end
        idle();
        check("perf_cycle_cnt", 64'(pif.cycle_cnt), 64'(10));
        check("perf_stall_cnt", 64'(pif.stall_cnt), 64'(2));
        check("perf_flush_cnt", 64'(pif.flush_cnt), 64'(1));
        do_reset("reset_after_perf");
`endif

        // Randomized traffic against the model; reset shortly after each freeze.
        n = 0;
        for (int i = 0; i < 400; i++) begin
            pif.ihit      = ($urandom_range(0, 9) < 8);
            pif.dhit      = $urandom_range(0, 1) == 1;
            pif.mem_dREN  = ($urandom_range(0, 9) < 2);
            pif.mem_dWEN  = !pif.mem_dREN && ($urandom_range(0, 9) < 2);
            pif.ex_dREN   = ($urandom_range(0, 9) < 3);
            pif.ex_regDst = 5'($urandom_range(0, 3));
            pif.de_rs     = 5'($urandom_range(0, 3));
            pif.de_rt     = 5'($urandom_range(0, 3));
            pif.br_taken  = ($urandom_range(0, 19) < 3);
            pif.de_halt   = ($urandom_range(0, 19) == 0);
            tick("random");
            if (m_halted) n++;
            if (n > 2) begin
                do_reset("random_reset");
                n = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pipeline_ctrl
